// File: rtl/vid_pkg.sv
// Shared video types and 720p timing constants for the pixel-domain blocks.
package vid_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    MUTE = 2'd2
  } arb_state_t;

  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 720;
  localparam int FRAME_W  = 1650;
  localparam int FRAME_H  = 750;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request.
module prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/video_source_arbiter.sv
// Frame-synchronous arbiter sharing the HDMI rgb input between pixel sources,
// with a muted gap of BLANK_FRAMES frames after each change of owner.
module video_source_arbiter
  import vid_pkg::*;
#(
  parameter int NUM_SRC      = 3,
  parameter int CX_W         = 11,
  parameter int SCREEN_W     = 1280,
  parameter int SCREEN_H     = 720,
  parameter int BLANK_FRAMES = 2
) (
  input  logic                  clk_pixel,
  input  logic                  sys_resetn,
  input  logic [CX_W-1:0]       cx,
  input  logic [CX_W-1:0]       cy,
  input  logic [NUM_SRC-1:0]    req,
  input  logic [NUM_SRC*24-1:0] src_rgb,
  output rgb_t                  rgb_out,
  output logic [NUM_SRC-1:0]    grant,
  output logic [2:0]            active_src,
  output logic                  switching,
  output logic [7:0]            switch_count
);

  localparam logic [CX_W-1:0] SCR_W_C   = CX_W'(SCREEN_W);
  localparam logic [CX_W-1:0] SCR_H_C   = CX_W'(SCREEN_H);
  localparam logic [3:0]      BLANK_CNT = 4'(BLANK_FRAMES);

  arb_state_t          state, state_n;
  logic [2:0]          target, target_n;
  logic [2:0]          active_n;
  logic [3:0]          mute_cnt, mute_cnt_n;
  logic [7:0]          count_n;
  logic                enc_valid;
  logic [2:0]          enc_idx;
  logic [2:0]          desired;
  logic                frame_start;
  logic                in_active;
  rgb_t                sel_rgb;
  logic [NUM_SRC-1:0]  grant_n;

  prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (3)
  ) u_prio_enc (
    .req   (req),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign frame_start = (cx == '0) && (cy == '0);
  assign in_active   = (cx < SCR_W_C) && (cy < SCR_H_C);
  assign desired     = enc_valid ? enc_idx : active_src;

  always_comb begin
    state_n    = state;
    target_n   = target;
    active_n   = active_src;
    mute_cnt_n = mute_cnt;
    count_n    = switch_count;
    case (state)
      RUN: begin
        if (desired != active_src) begin
          state_n  = PEND;
          target_n = desired;
        end
      end
      PEND: begin
        target_n = desired;
        if (desired == active_src) begin
          state_n = RUN;
        end else if (frame_start) begin
          active_n = target;
          count_n  = sat_inc8(switch_count);
          if (BLANK_FRAMES == 0) begin
            state_n = RUN;
          end else begin
            state_n    = MUTE;
            mute_cnt_n = BLANK_CNT;
          end
        end
      end
      MUTE: begin
        // Requests are deliberately ignored until the mute has run out.
        if (frame_start) begin
          mute_cnt_n = mute_cnt - 4'd1;
          if (mute_cnt == 4'd1) state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    sel_rgb = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_n == 3'(i)) sel_rgb = src_rgb[i*24 +: 24];
    end
  end

  assign grant_n = {{(NUM_SRC-1){1'b0}}, 1'b1} << active_n;

  // Registered outputs follow the next state so the new owner and the mute
  // both take effect on pixel (0,0) of the frame that starts the change.
  always_ff @(posedge clk_pixel or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state        <= RUN;
      target       <= '0;
      mute_cnt     <= '0;
      active_src   <= '0;
      grant        <= {{(NUM_SRC-1){1'b0}}, 1'b1};
      switch_count <= '0;
      switching    <= 1'b0;
      rgb_out      <= '0;
    end else begin
      state        <= state_n;
      target       <= target_n;
      mute_cnt     <= mute_cnt_n;
      active_src   <= active_n;
      grant        <= grant_n;
      switch_count <= count_n;
      switching    <= (state_n == PEND) || (state_n == MUTE);
      rgb_out      <= (state_n == MUTE || !in_active) ? 24'h000000 : sel_rgb;
    end
  end

endmodule
